// File: rtl/mux_n1_reg.sv
// mux_n1_reg: registered N-to-1 valid/ready stream mux with fixed-select or round-robin arbitration
module mux_n1_reg #(
    parameter int DATA_LENGTH = 8,
    parameter int N_CH = 4,
    parameter int SEL_W = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mode,
    input  logic [SEL_W-1:0]            sel,
    input  logic [N_CH*DATA_LENGTH-1:0] in_data,
    input  logic [N_CH-1:0]             in_valid,
    output logic [N_CH-1:0]             in_ready,
    output logic [DATA_LENGTH-1:0]      out_data,
    output logic [SEL_W-1:0]            out_ch,
    output logic                        out_valid,
    input  logic                        out_ready
);
    logic [SEL_W-1:0]     ptr;
    logic [SEL_W-1:0]     gnt_idx;
    logic [2**SEL_W-1:0]  valid_ext;
    logic                 gnt_vld;
    logic                 load_en;
    assign load_en = !out_valid || out_ready;
    always_comb begin
        // zero-padded to the full select range so out-of-range sel grants nothing
        valid_ext = '0;
        valid_ext[N_CH-1:0] = in_valid;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (!mode) begin
            gnt_vld = valid_ext[sel];
            gnt_idx = sel;
        end else begin
            // walk from farthest to nearest so the first valid channel after ptr wins
            for (int k = N_CH; k >= 1; k--) begin
                if (valid_ext[SEL_W'((int'(ptr) + k) % N_CH)]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'((int'(ptr) + k) % N_CH);
                end
            end
        end
    end
    assign in_ready = (gnt_vld && load_en) ? N_CH'(1) << gnt_idx : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SEL_W'(N_CH - 1);
        end else if (load_en) begin
            out_valid <= gnt_vld;
            if (gnt_vld) begin
                out_data <= in_data[int'(gnt_idx)*DATA_LENGTH +: DATA_LENGTH];
                out_ch   <= gnt_idx;
                if (mode) ptr <= gnt_idx;
            end
        end
    end
endmodule

// File: doc/mux_n1_reg.md
# mux_n1_reg

Parametrised, registered N-to-1 stream multiplexer for the median datapath, the successor of the plain combinational 2:1 select. It arbitrates N_CH sample channels onto one output register with valid/ready handshakes on every port. Two modes are supported: externally selected (fixed) and round-robin. It sits between the per-channel sample sources and the median window FIFO, so several input streams can share one median engine without sample loss.

## Interface
- DATA_LENGTH, 8, sample width in bits
- N_CH, 4, number of input channels (2..16)
- SEL_W, 2, select/channel-index width; 2^SEL_W >= N_CH is required
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = fixed (use sel), 1 = round-robin
- sel  in  SEL_W  channel index used in fixed mode
- in_data  in  N_CH*DATA_LENGTH  flattened samples; channel i occupies bits [i*DATA_LENGTH +: DATA_LENGTH]
- in_valid  in  N_CH  per-channel sample valid
- in_ready  out  N_CH  per-channel accept (combinational)
- out_data  out  DATA_LENGTH  registered sample
- out_ch  out  SEL_W  index of the channel that supplied out_data
- out_valid  out  1  out_data/out_ch valid
- out_ready  in  1  downstream accept

## Operation
- One-entry output register. load_en = !out_valid | out_ready.
- Grant (combinational, one-hot or none):
  - Fixed mode: grant = channel sel if sel < N_CH and in_valid[sel]; sel >= N_CH grants nothing.
  - Round-robin mode: search channels ptr+1, ptr+2, ... wrapping modulo N_CH; grant the first with in_valid set.
- in_ready[i] = grant[i] & load_en. No other channel sees in_ready high.
- Transfer on channel i when in_valid[i] & in_ready[i]. On the next edge: out_data <= channel i data, out_ch <= i, out_valid <= 1. In round-robin mode, ptr <= i.
- If load_en is set and there is no grant: out_valid <= 0 when out_ready drained the register; out_data and out_ch hold.
- While out_valid & !out_ready: out_data, out_ch and out_valid hold stable, and all in_ready are 0.
- ptr updates only on a round-robin transfer. Fixed-mode transfers leave ptr unchanged.
- A mode or sel change is purely combinational and takes effect in the same cycle's arbitration. ptr is retained across mode changes.
- Reset (async assert, sync release): out_valid = 0, out_data = 0, out_ch = 0, ptr = N_CH-1, so the first round-robin search starts at channel 0. A reset mid-transfer discards the held sample.

## Timing
- Latency: 1 cycle from an input transfer to out_valid.
- Throughput: 1 sample/cycle when out_ready is held high (simultaneous drain and load in the same cycle).
- in_ready depends combinationally on in_valid, mode, sel, out_valid and out_ready.
- No combinational path from in_valid or in_data to any out_* port.
- Simultaneous events:
  - Drain and load in the same edge: the new sample replaces the old one with no bubble.
  - With all channels valid in round-robin mode, grants rotate 0,1,...,N_CH-1,0.
- Outputs are driven entirely from flops. All out_* values are defined from reset.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 asynchronously. After release, in RR mode with all valid, the first grant is channel 0.
- Fixed mode, N_CH=4, sel=2, in_valid=4'b1111, ch2 data=0x5A, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0x5A, out_ch=2, out_valid=1. With sel=5 (SEL_W=3), in_ready=0 and out_valid falls after the drain.
- Round-robin fairness: all 4 channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles, with no bubbles.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_data/out_ch stable and in_ready=0 throughout. Raise out_ready -> held sample consumed and the next granted sample loaded on the same edge.
- Sparse RR: only ch1 and ch3 valid, ptr=1 -> grant ch3, then ch1, then ch3. Switch mode to fixed with sel=3 mid-sequence, then back to RR -> resumes searching after the last RR-granted channel.
